// File: rtl/uart_tx_engine_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_engine_cfg
// Description : Runtime-configurable UART transmitter. Pops one word from the
//               TX FIFO per frame and sends it as start bit, 5..MAX_DATA_BITS
//               data bits (LSB first), optional even/odd parity, and 1 or 2
//               stop bits. The bit period is OSR oversample ticks.
//               Frame format is latched in FETCH, once per frame.
//               Optional line-break generation is enabled by the macro
//               UART_TX_BREAK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_engine_cfg #(
    parameter int OSR           = 16,
    parameter int MAX_DATA_BITS = 9
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     osr_tick_i,
    input  logic                     tx_fifo_valid_i,
    input  logic [MAX_DATA_BITS-1:0] tx_fifo_data_i,
    output logic                     tx_fifo_ren_o,
    input  logic                     tx_en_i,
    input  logic [3:0]               data_bits_i,
    input  logic [1:0]               parity_mode_i,
    input  logic                     stop_bits_i,
`ifdef UART_TX_BREAK_EN
    input  logic                     send_break_i,
`endif
    output logic                     tx_busy_o,
    output logic                     tx_done_o,
    output logic                     transmit_bit_o
);

    localparam int         OSR_W    = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [3:0] MIN_BITS = 4'd5;
    localparam logic [3:0] MAX_BITS = 4'(MAX_DATA_BITS);

`ifdef UART_TX_BREAK_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5,
        S_BREAK  = 3'd6,
        S_MARK   = 3'd7
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;
`endif

    state_t                   state_q;
    logic [OSR_W-1:0]         osr_cnt_q;
    logic [4:0]               bit_cnt_q;
    logic [MAX_DATA_BITS-1:0] shift_q;
    logic [3:0]               nbits_q;
    logic                     par_en_q;
    logic                     par_bit_q;
    logic                     stop2_q;
    logic                     tx_q;
    logic                     ren_q;
    logic                     busy_q;
    logic                     done_q;

    logic [3:0]               w_nbits;
    logic [MAX_DATA_BITS-1:0] w_mask;
    logic                     w_par_en;
    logic                     w_parity;
    logic                     w_baud_tick;
    logic                     w_cnt_en;
    logic                     w_brk_go;

    // Clamp the requested data width into the legal 5..MAX_DATA_BITS range
    always_comb begin
        w_nbits = data_bits_i;
        if (data_bits_i < MIN_BITS) begin
            w_nbits = MIN_BITS;
        end else if (data_bits_i > MAX_BITS) begin
            w_nbits = MAX_BITS;
        end
    end

    // Mask of the bits that are actually sent, so parity ignores upper bits
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_DATA_BITS; i++) begin
            w_mask[i] = (i < int'(w_nbits));
        end
    end

    // Mode 01 = even, 10 = odd; 00 and 11 carry no parity bit
    assign w_par_en    = ^parity_mode_i;
    assign w_parity    = (^(tx_fifo_data_i & w_mask)) ^ parity_mode_i[1];
    assign w_baud_tick = osr_tick_i && (osr_cnt_q == OSR_W'(OSR - 1));

`ifdef UART_TX_BREAK_EN
    logic [4:0] brk_len_q;
    logic [4:0] w_brk_len;

    // Break length tracks a full frame of the live configuration
    assign w_brk_go  = (state_q == S_IDLE) && tx_en_i && send_break_i;
    assign w_brk_len = 5'd2 + {1'b0, w_nbits} + {4'b0, w_par_en} + {4'b0, stop_bits_i};
    assign w_cnt_en  = (state_q == S_START) || (state_q == S_DATA) ||
                       (state_q == S_PARITY) || (state_q == S_STOP) ||
                       (state_q == S_BREAK) || (state_q == S_MARK) || w_brk_go;
`else
    assign w_brk_go  = 1'b0;
    assign w_cnt_en  = (state_q == S_START) || (state_q == S_DATA) ||
                       (state_q == S_PARITY) || (state_q == S_STOP) || w_brk_go;
`endif

    // Oversample divider; held at zero in IDLE and FETCH so ticks there are dropped
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            osr_cnt_q <= '0;
        end else if (!w_cnt_en) begin
            osr_cnt_q <= '0;
        end else if (osr_tick_i) begin
            osr_cnt_q <= w_baud_tick ? '0 : osr_cnt_q + OSR_W'(1);
        end
    end

    // Frame sequencer with registered line, pop, busy and done outputs
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            nbits_q   <= MIN_BITS;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            ren_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_len_q <= '0;
`endif
        end else begin
            ren_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tx_q      <= 1'b1;
                    bit_cnt_q <= '0;
`ifdef UART_TX_BREAK_EN
                    if (w_brk_go) begin
                        state_q   <= S_BREAK;
                        busy_q    <= 1'b1;
                        tx_q      <= 1'b0;
                        brk_len_q <= w_brk_len;
                    end else
`endif
                    if (tx_en_i && tx_fifo_valid_i) begin
                        state_q <= S_FETCH;
                        busy_q  <= 1'b1;
                        ren_q   <= 1'b1;
                    end
                end
                S_FETCH: begin
                    shift_q   <= tx_fifo_data_i;
                    nbits_q   <= w_nbits;
                    par_en_q  <= w_par_en;
                    par_bit_q <= w_parity;
                    stop2_q   <= stop_bits_i;
                    bit_cnt_q <= '0;
                    tx_q      <= 1'b0;
                    state_q   <= S_START;
                end
                S_START: begin
                    if (w_baud_tick) begin
                        state_q <= S_DATA;
                        tx_q    <= shift_q[0];
                    end
                end
                S_DATA: begin
                    if (w_baud_tick) begin
                        shift_q <= shift_q >> 1;
                        if (bit_cnt_q == ({1'b0, nbits_q} - 5'd1)) begin
                            bit_cnt_q <= '0;
                            if (par_en_q) begin
                                state_q <= S_PARITY;
                                tx_q    <= par_bit_q;
                            end else begin
                                state_q <= S_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            tx_q      <= shift_q[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (w_baud_tick) begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_baud_tick) begin
                        if (bit_cnt_q[0] == stop2_q) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end
                end
`ifdef UART_TX_BREAK_EN
                S_BREAK: begin
                    if (w_baud_tick) begin
                        if (bit_cnt_q == (brk_len_q - 5'd1)) begin
                            state_q   <= S_MARK;
                            bit_cnt_q <= '0;
                            tx_q      <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end
                end
                S_MARK: begin
                    if (w_baud_tick) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx_fifo_ren_o  = ren_q;
    assign tx_busy_o      = busy_q;
    assign tx_done_o      = done_q;
    assign transmit_bit_o = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_engine_cfg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_tx_engine_cfg
// Description : Scoreboard bench for uart_tx_engine_cfg. Stimulus pushes FIFO
//               words together with hand-written expected line patterns; a
//               monitor follows each frame tick by tick and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_engine_cfg;

    localparam int OSR = 16;
    localparam int MDB = 9;

    logic           clk_i           = 1'b0;
    logic           reset_n_i       = 1'b0;
    logic           osr_tick_i      = 1'b0;
    logic           tx_fifo_valid_i = 1'b0;
    logic [MDB-1:0] tx_fifo_data_i  = '0;
    logic           tx_en_i         = 1'b1;
    logic [3:0]     data_bits_i     = 4'd8;
    logic [1:0]     parity_mode_i   = 2'd0;
    logic           stop_bits_i     = 1'b0;
`ifdef UART_TX_BREAK_EN
    logic           send_break_i    = 1'b0;
`endif
    logic           tx_fifo_ren_o;
    logic           tx_busy_o;
    logic           tx_done_o;
    logic           transmit_bit_o;

    uart_tx_engine_cfg #(.OSR(OSR), .MAX_DATA_BITS(MDB)) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .osr_tick_i      (osr_tick_i),
        .tx_fifo_valid_i (tx_fifo_valid_i),
        .tx_fifo_data_i  (tx_fifo_data_i),
        .tx_fifo_ren_o   (tx_fifo_ren_o),
        .tx_en_i         (tx_en_i),
        .data_bits_i     (data_bits_i),
        .parity_mode_i   (parity_mode_i),
        .stop_bits_i     (stop_bits_i),
`ifdef UART_TX_BREAK_EN
        .send_break_i    (send_break_i),
`endif
        .tx_busy_o       (tx_busy_o),
        .tx_done_o       (tx_done_o),
        .transmit_bit_o  (transmit_bit_o)
    );

    // Scoreboard: expected line pattern per frame, first character sent first
    string          exp_pat_q[$];
    bit             exp_b2b_q[$];
    bit             exp_brk_q[$];
    logic [MDB-1:0] fifo_q[$];

    int    n_checks = 0;
    int    n_fail   = 0;
    bit    in_frame = 1'b0;
    string cur;
    int    len, nticks, since_done, bad_idx;
    bit    ren_chk, bit_bad, bad_val, exp_bit, skip, cur_b2b, cur_brk;

    always #5 clk_i = ~clk_i;

    // Oversample strobe: high every other clock cycle
    initial begin
        forever begin
            @(posedge clk_i);
            #1 osr_tick_i = ~osr_tick_i;
        end
    end

    // Simple FIFO model: head word shown, popped after the FETCH cycle
    initial begin
        forever begin
            @(negedge clk_i);
            if (tx_fifo_ren_o) begin
                @(posedge clk_i);
                #1;
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            end
            tx_fifo_valid_i = (fifo_q.size() > 0);
            tx_fifo_data_i  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Monitor: follows each frame tick by tick against the scoreboard head
    always @(negedge clk_i) begin
        skip = 1'b0;
        if (!reset_n_i) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame) begin
                since_done++;
                if (tx_done_o) fail_now("spurious_done");
                if (tx_fifo_ren_o) begin
                    if (exp_pat_q.size() == 0) begin
                        fail_now("unexpected_ren");
                    end else begin
                        cur     = exp_pat_q.pop_front();
                        cur_b2b = exp_b2b_q.pop_front();
                        cur_brk = exp_brk_q.pop_front();
                        if (cur_brk) fail_now("ren_on_break");
                        if (cur_b2b) check("b2b_gap", since_done, 1);
                        in_frame = 1'b1;
                        len      = cur.len();
                        nticks   = 0;
                        ren_chk  = 1'b1;
                        bit_bad  = 1'b0;
                        skip     = 1'b1;
                    end
                end else if (tx_busy_o) begin
                    if (exp_brk_q.size() == 0 || !exp_brk_q[0]) begin
                        fail_now("busy_without_ren");
                    end else begin
                        cur      = exp_pat_q.pop_front();
                        cur_b2b  = exp_b2b_q.pop_front();
                        cur_brk  = exp_brk_q.pop_front();
                        in_frame = 1'b1;
                        len      = cur.len();
                        nticks   = 0;
                        ren_chk  = 1'b0;
                        bit_bad  = 1'b0;
                    end
                end
            end
            if (in_frame && !skip) begin
                if (ren_chk) begin
                    check("ren_one_cycle", tx_fifo_ren_o, 0);
                    ren_chk = 1'b0;
                end
                if (nticks == len * OSR) begin
                    check("done_pulse", tx_done_o, 1);
                    check("busy_after_frame", tx_busy_o, 0);
                    in_frame   = 1'b0;
                    since_done = 0;
                end else if (tx_done_o) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL done_early: done after %0d ticks, required %0d", nticks, len * OSR);
                    in_frame   = 1'b0;
                    since_done = 0;
                end else if (osr_tick_i) begin
                    exp_bit = (cur.getc(nticks / OSR) == 8'h31);
                    if (transmit_bit_o !== exp_bit || tx_busy_o !== 1'b1) begin
                        bit_bad = 1'b1;
                        bad_val = transmit_bit_o;
                        bad_idx = nticks / OSR;
                    end
                    nticks++;
                    if (nticks % OSR == 0) begin
                        n_checks++;
                        if (bit_bad) begin
                            n_fail++;
                            $display("FAIL frame_bit[%0d] of %s: line=%0b busy=%0b expected line=%0b busy=1",
                                     bad_idx, cur, bad_val, tx_busy_o, exp_bit);
                        end
                        bit_bad = 1'b0;
                    end
                end
            end
        end
    end

    task automatic cfg(input int db, input int pm, input int sb);
        data_bits_i   = 4'(db);
        parity_mode_i = 2'(pm);
        stop_bits_i   = 1'(sb);
    endtask

    task automatic push(input logic [MDB-1:0] d, input string pat, input bit b2b);
        exp_pat_q.push_back(pat);
        exp_b2b_q.push_back(b2b);
        exp_brk_q.push_back(1'b0);
        fifo_q.push_back(d);
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 4000; i++) begin
            if (exp_pat_q.size() == 0 && !in_frame && fifo_q.size() == 0) break;
            @(negedge clk_i);
        end
        if (i == 4000) fail_now({name, "_timeout"});
        repeat (3) @(negedge clk_i);
    endtask

    task automatic wait_ren(input string name);
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (tx_fifo_ren_o) break;
        end
        if (i == 200) fail_now({name, "_ren_timeout"});
    endtask

    initial begin
        int rens;
        int i;
        repeat (3) @(negedge clk_i);
        check("reset_line", transmit_bit_o, 1);
        check("reset_busy", tx_busy_o, 0);
        check("reset_ren", tx_fifo_ren_o, 0);
        check("reset_done", tx_done_o, 0);
        reset_n_i = 1'b1;
        repeat (4) @(negedge clk_i);

        // 8N1 0xA5
        cfg(8, 0, 0);
        push(9'h0A5, "0101001011", 1'b0);
        wait_idle("8n1");
        // 7E2 0x55
        cfg(7, 1, 1);
        push(9'h055, "01010101011", 1'b0);
        wait_idle("7e2");
        // 9O1 0x1FF
        cfg(9, 2, 0);
        push(9'h1FF, "011111111101", 1'b0);
        wait_idle("9o1");
        // Back-to-back 8N1 frames
        cfg(8, 0, 0);
        push(9'h03C, "0001111001", 1'b0);
        push(9'h0C3, "0110000111", 1'b1);
        wait_idle("b2b");
        // data_bits below 5 clamps to 5
        cfg(3, 0, 0);
        push(9'h03F, "0111111", 1'b0);
        wait_idle("clamp_lo");
        // 5E1: bits above the width are excluded from parity
        cfg(5, 1, 0);
        push(9'h0E0, "00000001", 1'b0);
        wait_idle("par_mask");
        // data_bits above max clamps to 9; mode 11 sends no parity
        cfg(15, 3, 0);
        push(9'h155, "01010101011", 1'b0);
        wait_idle("clamp_hi");
        // 6O1, config altered while busy
        cfg(6, 2, 0);
        push(9'h02A, "001010101", 1'b0);
        wait_ren("cfg_change");
        @(negedge clk_i);
        cfg(8, 1, 1);
        wait_idle("cfg_change");

        // tx_en dropped mid-frame: frame finishes, next word held back
        cfg(8, 0, 0);
        push(9'h0A5, "0101001011", 1'b0);
        wait_ren("en_low");
        tx_en_i = 1'b0;
        push(9'h081, "0100000011", 1'b0);
        for (i = 0; i < 1000; i++) begin
            if (exp_pat_q.size() == 1 && !in_frame) break;
            @(negedge clk_i);
        end
        if (i == 1000) fail_now("en_low_frame_timeout");
        rens = 0;
        repeat (60) begin
            @(negedge clk_i);
            if (tx_fifo_ren_o) rens++;
        end
        check("no_ren_while_disabled", rens, 0);
        check("idle_busy_disabled", tx_busy_o, 0);
        tx_en_i = 1'b1;
        wait_idle("en_high");

        // Asynchronous reset in the middle of DATA of a 0x00 frame
        push(9'h000, "0000000001", 1'b0);
        wait_ren("reset_mid");
        repeat (40) @(negedge clk_i);
        check("mid_data_line_low", transmit_bit_o, 0);
        #2 reset_n_i = 1'b0;
        #1;
        check("async_reset_line", transmit_bit_o, 1);
        check("async_reset_busy", tx_busy_o, 0);
        check("async_reset_ren", tx_fifo_ren_o, 0);
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        rens = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (tx_fifo_ren_o) rens++;
        end
        check("post_reset_no_ren", rens, 0);
        check("post_reset_line", transmit_bit_o, 1);
        push(9'h081, "0100000011", 1'b0);
        wait_idle("post_reset");

`ifdef UART_TX_BREAK_EN
        // 8N1 break: 10 low bit periods, 1 high, no FIFO pop
        cfg(8, 0, 0);
        exp_pat_q.push_back("00000000001");
        exp_b2b_q.push_back(1'b0);
        exp_brk_q.push_back(1'b1);
        @(negedge clk_i);
        if (osr_tick_i) @(negedge clk_i);
        send_break_i = 1'b1;
        @(negedge clk_i);
        send_break_i = 1'b0;
        wait_idle("break");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
